// File: rtl/uart_tx_driver.sv
// ---------------------------------------------------------------------------
// uart_tx_driver
//
// Purpose:
//   8N1 UART transmitter with a small byte FIFO in front of it. A producer
//   pushes bytes with a valid/ready handshake. The serialiser pops one byte at
//   a time and shifts it out LSB first: a start bit (0), 8 data bits and a stop
//   bit (1). Each bit is held for BAUD_DIV clock cycles. When the FIFO still
//   holds a byte at the end of a stop bit, the next frame starts on the
//   following cycle, so there is no idle gap between frames.
//
// Parameters:
//   BAUD_DIV    clock cycles per UART bit (2..65535)
//   FIFO_DEPTH  byte entries in the FIFO (power of two, 2..16)
//
// Ports:
//   clock       sole clock, rising edge
//   reset       asynchronous, active-high reset
//   in_valid    producer presents a byte
//   in_data     byte to transmit, sampled only on an accepting edge
//   in_ready    FIFO can accept a byte this cycle (registered state only)
//   txd         serial output, idle high, driven straight from a flop
//   busy        a frame is on the line or the FIFO is non-empty
//   fifo_count  bytes currently held in the FIFO
// ---------------------------------------------------------------------------
module uart_tx_driver #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       txd,
    output logic       busy,
    output logic [4:0] fifo_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [4:0]  DEPTH_CNT = 5'(FIFO_DEPTH);

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [4:0]    r_count;

    // Serialiser state
    logic [1:0]    r_state;
    logic [15:0]   r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_txd;

    logic          w_push;
    logic          w_pop;
    logic          w_bit_done;
    logic          w_fifo_empty;

    assign w_fifo_empty = (r_count == 5'd0);
    assign w_bit_done   = (r_baud == BAUD_LAST);

    // Ready depends only on the registered count, so a pop in the same cycle
    // never allows a push into a full FIFO.
    assign in_ready = (r_count != DEPTH_CNT);
    assign w_push   = in_valid && in_ready;

    // A byte leaves the FIFO when the line is idle, or at the last cycle of a
    // stop bit so the next start bit follows back to back.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == IDLE) || ((r_state == STOP) && w_bit_done));

    assign txd        = r_txd;
    assign fifo_count = r_count;
    assign busy       = (r_state != IDLE) || !w_fifo_empty;

    // Storage array has no reset: stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers are AW bits wide and FIFO_DEPTH is a power of two, so they wrap
    // naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // r_txd is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state and comes straight from a flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_txd  <= 1'b1;
                    r_baud <= 16'd0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= START;
                        r_txd   <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_baud    <= 16'd0;
                        r_bit_idx <= 3'd0;
                        r_state   <= DATA;
                        r_txd     <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_baud <= 16'd0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            // Next bit to appear is shift[1], which becomes
                            // shift[0] after this shift.
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                STOP: begin
                    if (w_bit_done) begin
                        r_baud    <= 16'd0;
                        r_bit_idx <= 3'd0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_state <= START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_txd   <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule
